// File: rtl/mem_pkg.sv
// Shared constants, FSM state encoding and the request legality check
// for the LSU-to-NextRam bridge.
package mem_pkg;

  localparam int MEM_DEPTH_DFLT = 2048;
  localparam int ADDR_W_DFLT    = 16;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {IDLE, RD, MWR, WR, LRESP, SRESP, ERR} lsu_state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Any one of: bad funct3, misaligned half/word, or address past the RAM.
  function automatic logic req_error(input lsu_req_t r, input logic [31:0] lim);
    logic bad_f3, bad_al;
    if (r.we) bad_f3 = (r.funct3 > F3_W);
    else      bad_f3 = !(r.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    bad_al = ((r.funct3 == F3_H || r.funct3 == F3_HU) && r.addr[0]) ||
             ((r.funct3 == F3_W) && (r.addr[1:0] != 2'b00));
    return bad_f3 || bad_al || (r.addr >= lim);
  endfunction

endpackage

// File: rtl/lsu_ram_bridge_if.sv
// Request/response channel plus the NextRam port of the bridge.
interface lsu_ram_bridge_if #(parameter int ADDR_W = 16);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic              ram_ren;
  logic [ADDR_W-1:0] ram_raddr;
  logic [31:0]       ram_rdata;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_waddr;
  logic [1:0]        ram_ben;
  logic [31:0]       ram_wdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
           ram_ren, ram_raddr, ram_wen, ram_waddr, ram_ben, ram_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           ram_ren, ram_raddr, ram_wen, ram_waddr, ram_ben, ram_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: load extract/extend and sub-word store merge.
module lsu_lane_align
  import mem_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic [2:0]               i_funct3,
  input  logic [1:0]               i_lane,
  input  logic [NUM_LANES*8-1:0]   i_word,
  input  logic [NUM_LANES*8-1:0]   i_wdata,
  output logic [NUM_LANES*8-1:0]   o_load,
  output logic [NUM_LANES*8-1:0]   o_merge
);

  logic [31:0] w_sh;
  assign w_sh = i_word >> {i_lane, 3'b000};

  always_comb begin
    case (i_funct3)
      F3_B:    o_load = {{24{w_sh[7]}}, w_sh[7:0]};
      F3_H:    o_load = {{16{w_sh[15]}}, w_sh[15:0]};
      F3_W:    o_load = i_word;
      F3_BU:   o_load = {24'd0, w_sh[7:0]};
      F3_HU:   o_load = {16'd0, w_sh[15:0]};
      default: o_load = '0;
    endcase
  end

  // Each lane either keeps the RAM byte or takes the matching store byte.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam logic [1:0] LN = 2'(g);
    logic       w_hit;
    logic [7:0] w_src;
    always_comb begin
      w_hit = 1'b0;
      w_src = i_wdata[8*g +: 8];
      case (i_funct3)
        F3_B: begin
          w_hit = (i_lane == LN);
          w_src = i_wdata[7:0];
        end
        F3_H: begin
          w_hit = (i_lane[1] == LN[1]);
          w_src = LN[0] ? i_wdata[15:8] : i_wdata[7:0];
        end
        F3_W:    w_hit = 1'b1;
        default: w_hit = 1'b0;
      endcase
    end
    assign o_merge[8*g +: 8] = w_hit ? w_src : i_word[8*g +: 8];
  end

endmodule

// File: rtl/lsu_ram_bridge.sv
// RV32I load/store front end for the 2048x32 NextRam; sub-word stores are
// done as read-modify-write so the RAM only ever sees full-word writes.
module lsu_ram_bridge
  import mem_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DFLT,
  parameter int ADDR_W    = ADDR_W_DFLT
) (
  input  logic            clk,
  input  logic            rst,
  lsu_ram_bridge_if.slave bus
);

  localparam logic [31:0] BYTE_LIM = 32'(MEM_DEPTH * 4);

  lsu_state_t        r_state;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_waddr;
  logic [1:0]        r_lane;
  logic [31:0]       r_wdata;
  logic              r_ren, r_wen, r_rsp, r_rsp_err;

  lsu_req_t    w_req;
  logic        w_err;
  logic [31:0] w_load, w_merge;

  always_comb begin
    w_req.we     = bus.req_we;
    w_req.funct3 = bus.req_funct3;
    w_req.addr   = bus.req_addr;
    w_req.wdata  = bus.req_wdata;
  end
  assign w_err = req_error(w_req, BYTE_LIM);

  // Strobes are registered alongside the transition into the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_f3      <= '0;
      r_waddr   <= '0;
      r_lane    <= '0;
      r_wdata   <= '0;
      r_ren     <= 1'b0;
      r_wen     <= 1'b0;
      r_rsp     <= 1'b0;
      r_rsp_err <= 1'b0;
    end else begin
      r_ren     <= 1'b0;
      r_wen     <= 1'b0;
      r_rsp     <= 1'b0;
      r_rsp_err <= 1'b0;
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_we    <= bus.req_we;
          r_f3    <= bus.req_funct3;
          r_waddr <= bus.req_addr[ADDR_W+1:2];
          r_lane  <= bus.req_addr[1:0];
          r_wdata <= bus.req_wdata;
          if (w_err) begin
            r_state   <= ERR;
            r_rsp     <= 1'b1;
            r_rsp_err <= 1'b1;
          end else if (bus.req_we && bus.req_funct3 == F3_W) begin
            r_state <= WR;
            r_wen   <= 1'b1;
          end else begin
            r_state <= RD;
            r_ren   <= 1'b1;
          end
        end
        RD: if (r_we) begin
          r_state <= MWR;
          r_wen   <= 1'b1;
        end else begin
          r_state <= LRESP;
          r_rsp   <= 1'b1;
        end
        MWR, WR: begin
          r_state <= SRESP;
          r_rsp   <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  lsu_lane_align #(.NUM_LANES(4)) u_align (
    .i_funct3 (r_f3),
    .i_lane   (r_lane),
    .i_word   (bus.ram_rdata),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  assign bus.req_ready  = (r_state == IDLE) && !rst;
  assign bus.ram_ren    = r_ren;
  assign bus.ram_raddr  = r_waddr;
  assign bus.ram_wen    = r_wen;
  assign bus.ram_waddr  = r_waddr;
  assign bus.ram_ben    = 2'b00;
  assign bus.ram_wdata  = r_wen ? ((r_state == MWR) ? w_merge : r_wdata) : '0;
  assign bus.resp_valid = r_rsp;
  assign bus.resp_err   = r_rsp_err;
  assign bus.resp_rdata = (r_state == LRESP) ? w_load : '0;

endmodule

// File: tb/tb_lsu_ram_bridge.sv
// Bench for lsu_ram_bridge: behavioural NextRam, vector table, scoreboard of
// expected responses, and hand-written sequences for timing and reset cases.
module tb_lsu_ram_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_ram_bridge_if #(.ADDR_W(16)) bus ();

  lsu_ram_bridge #(.MEM_DEPTH(2048), .ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (bus.ram_ren) bus.ram_rdata <= mem[bus.ram_raddr[10:0]];
    if (bus.ram_wen) mem[bus.ram_waddr[10:0]] <= bus.ram_wdata;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          t;
    int          tag;
  } exp_t;
  exp_t exp_q[$];

  int both_viol = 0, ben_viol = 0, wd_viol = 0;
  int ren_cnt = 0, wen_cnt = 0, rsp_cnt = 0;
  logic [15:0] last_raddr, last_waddr;
  logic [31:0] last_wdata;

  always @(negedge clk) begin
    if (bus.ram_ren && bus.ram_wen) both_viol++;
    if (bus.ram_ben !== 2'b00) ben_viol++;
    if (!bus.ram_wen && bus.ram_wdata !== 32'd0) wd_viol++;
    if (bus.ram_ren) begin ren_cnt++; last_raddr = bus.ram_raddr; end
    if (bus.ram_wen) begin wen_cnt++; last_waddr = bus.ram_waddr; last_wdata = bus.ram_wdata; end
    if (bus.resp_valid) begin
      rsp_cnt++;
      if (exp_q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("r%0d_err", e.tag), {31'd0, bus.resp_err}, {31'd0, e.err});
        chk($sformatf("r%0d_rdata", e.tag), bus.resp_rdata, e.rdata);
        chk($sformatf("r%0d_latency", e.tag), 32'(cyc - e.t), 32'(e.lat));
      end
    end
  end

  int tag_n = 0;

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                      input int e_lat, input bit push, input bit drop, output int t_acc);
    bit acc = 1'b0;
    t_acc = -1;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        acc = 1'b1;
        t_acc = cyc;
      end
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    else if (push) begin
      exp_t e;
      e.err = e_err; e.rdata = e_rd; e.lat = e_lat; e.t = t_acc; e.tag = tag_n;
      exp_q.push_back(e);
    end
    tag_n++;
    @(posedge clk); #1;
    if (drop) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;
  localparam int NV = 24;
  vec_t vt [NV];

  initial begin
    int ta, tb2, r0, w0, k0;

    vt[0]  = '{1'b1, 3'd2, 32'h10,       32'h80112233, 1'b0, 32'h00000000, 2};
    vt[1]  = '{1'b0, 3'd0, 32'h13,       32'h0,        1'b0, 32'hFFFFFF80, 2};
    vt[2]  = '{1'b0, 3'd4, 32'h13,       32'h0,        1'b0, 32'h00000080, 2};
    vt[3]  = '{1'b0, 3'd1, 32'h12,       32'h0,        1'b0, 32'hFFFF8011, 2};
    vt[4]  = '{1'b0, 3'd5, 32'h12,       32'h0,        1'b0, 32'h00008011, 2};
    vt[5]  = '{1'b0, 3'd0, 32'h10,       32'h0,        1'b0, 32'h00000033, 2};
    vt[6]  = '{1'b0, 3'd1, 32'h10,       32'h0,        1'b0, 32'h00002233, 2};
    vt[7]  = '{1'b1, 3'd1, 32'h12,       32'h1234CAFE, 1'b0, 32'h00000000, 3};
    vt[8]  = '{1'b0, 3'd2, 32'h10,       32'h0,        1'b0, 32'hCAFE2233, 2};
    vt[9]  = '{1'b1, 3'd0, 32'h13,       32'h000000A5, 1'b0, 32'h00000000, 3};
    vt[10] = '{1'b0, 3'd2, 32'h10,       32'h0,        1'b0, 32'hA5FE2233, 2};
    vt[11] = '{1'b1, 3'd2, 32'h1FFC,     32'h0BADF00D, 1'b0, 32'h00000000, 2};
    vt[12] = '{1'b0, 3'd4, 32'h1FFF,     32'h0,        1'b0, 32'h0000000B, 2};
    vt[13] = '{1'b0, 3'd5, 32'h1FFE,     32'h0,        1'b0, 32'h00000BAD, 2};
    vt[14] = '{1'b0, 3'd2, 32'h2000,     32'h0,        1'b1, 32'h00000000, 1};
    vt[15] = '{1'b1, 3'd2, 32'h2000,     32'h12345678, 1'b1, 32'h00000000, 1};
    vt[16] = '{1'b0, 3'd1, 32'h15,       32'h0,        1'b1, 32'h00000000, 1};
    vt[17] = '{1'b0, 3'd2, 32'h12,       32'h0,        1'b1, 32'h00000000, 1};
    vt[18] = '{1'b0, 3'd3, 32'h10,       32'h0,        1'b1, 32'h00000000, 1};
    vt[19] = '{1'b1, 3'd4, 32'h10,       32'h0,        1'b1, 32'h00000000, 1};
    vt[20] = '{1'b1, 3'd1, 32'h13,       32'h0,        1'b1, 32'h00000000, 1};
    vt[21] = '{1'b0, 3'd0, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h00000000, 1};
    vt[22] = '{1'b0, 3'd6, 32'h10,       32'h0,        1'b1, 32'h00000000, 1};
    vt[23] = '{1'b0, 3'd2, 32'h10,       32'h0,        1'b0, 32'hA5FE2233, 2};

    for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
    mem[4] = 32'h8899AABB;
    mem[8] = 32'h55667788;
    bus.ram_rdata  = 32'd0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;

    // Outputs held at zero while in reset.
    repeat (3) @(negedge clk);
    chk("rst_req_ready",  {31'd0, bus.req_ready},  32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_ram_ren",    {31'd0, bus.ram_ren},    32'd0);
    chk("rst_ram_wen",    {31'd0, bus.ram_wen},    32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;

    // LW: read strobe one cycle after accept with the word address.
    send(1'b0, 3'd2, 32'h10, 32'd0, 1'b0, 32'h8899AABB, 2, 1'b1, 1'b1, ta);
    @(negedge clk);
    chk("lw_ren_t1",   {31'd0, bus.ram_ren}, 32'd1);
    chk("lw_raddr_t1", {16'd0, bus.ram_raddr}, 32'd4);
    drain();

    // SB read-modify-write timing and merged data.
    send(1'b1, 3'd2, 32'h10, 32'h11223344, 1'b0, 32'd0, 2, 1'b1, 1'b1, ta);
    drain();
    send(1'b1, 3'd0, 32'h11, 32'hDEADBEEF, 1'b0, 32'd0, 3, 1'b1, 1'b1, ta);
    @(negedge clk);
    chk("sb_ren_t1", {30'd0, bus.ram_ren, bus.ram_wen}, 32'd2);
    @(negedge clk);
    chk("sb_wen_t2",   {30'd0, bus.ram_ren, bus.ram_wen}, 32'd1);
    chk("sb_waddr_t2", {16'd0, bus.ram_waddr}, 32'd4);
    chk("sb_wdata_t2", bus.ram_wdata, 32'h1122EF44);
    chk("sb_ben_t2",   {30'd0, bus.ram_ben}, 32'd0);
    drain();
    send(1'b0, 3'd2, 32'h10, 32'd0, 1'b0, 32'h1122EF44, 2, 1'b1, 1'b1, ta);
    drain();

    for (int i = 0; i < NV; i++) begin
      send(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, vt[i].err, vt[i].rdata,
           vt[i].lat, 1'b1, 1'b1, ta);
      drain();
    end

    // Rejected requests never touch the RAM.
    r0 = ren_cnt; w0 = wen_cnt;
    send(1'b1, 3'd2, 32'h2000, 32'hCAFEF00D, 1'b1, 32'd0, 1, 1'b1, 1'b1, ta);
    drain();
    send(1'b0, 3'd1, 32'h15, 32'd0, 1'b1, 32'd0, 1, 1'b1, 1'b1, ta);
    drain();
    chk("err_no_ren", 32'(ren_cnt - r0), 32'd0);
    chk("err_no_wen", 32'(wen_cnt - w0), 32'd0);

    // Reset while the SH is in its read phase: abort, no write, no response.
    w0 = wen_cnt; k0 = rsp_cnt;
    send(1'b1, 3'd1, 32'h22, 32'h0000ABCD, 1'b0, 32'd0, 3, 1'b0, 1'b0, ta);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    chk("midrst_ren",   {31'd0, bus.ram_ren},    32'd0);
    chk("midrst_wen",   {31'd0, bus.ram_wen},    32'd0);
    chk("midrst_ready", {31'd0, bus.req_ready},  32'd0);
    chk("midrst_resp",  {31'd0, bus.resp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", {31'd0, bus.req_ready}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_write", 32'(wen_cnt - w0), 32'd0);
    chk("midrst_no_resp",  32'(rsp_cnt - k0), 32'd0);
    chk("midrst_mem8",     mem[8], 32'h55667788);

    // Back-to-back SW then LW with req_valid held high.
    send(1'b1, 3'd2, 32'h40, 32'h600DCAFE, 1'b0, 32'd0, 2, 1'b1, 1'b0, ta);
    send(1'b0, 3'd2, 32'h40, 32'd0, 1'b0, 32'h600DCAFE, 2, 1'b1, 1'b1, tb2);
    chk("b2b_accept_gap", 32'(tb2 - ta), 32'd3);
    drain();

    chk("ren_wen_overlap",  32'(both_viol), 32'd0);
    chk("ben_nonzero",      32'(ben_viol),  32'd0);
    chk("wdata_when_idle",  32'(wd_viol),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_ram_bridge.md
Name: lsu_ram_bridge

Overview:
Load/store front end that sits directly upstream of the 2048x32 NextRam. It accepts byte-addressed RV32I load/store requests and checks alignment and range. It converts requests into word-addressed RAM reads and writes. Byte and halfword stores are done as a read-modify-write with full-word writes, so the RAM's offset write modes (ben!=0) are never used. Load data comes back sign- or zero-extended with a valid pulse.

Parameters:
MEM_DEPTH, 2048, RAM depth in 32-bit words; a byte address is legal iff addr < MEM_DEPTH*4.
ADDR_W, 16, RAM word-address width.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request offered
req_ready  out  1  request accepted when valid&ready
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  in  32  byte address
req_wdata  in  32  store data, LSB-justified
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  request rejected (qualifies resp_valid)
resp_rdata  out  32  extended load data; 0 for stores/errors
ram_ren  out  1  RAM read enable
ram_raddr  out  ADDR_W  RAM read word address
ram_rdata  in  32  RAM read data, valid the cycle after ram_ren
ram_wen  out  1  RAM write enable
ram_waddr  out  ADDR_W  RAM write word address
ram_ben  out  2  RAM byte offset; driven 2'b00 always
ram_wdata  out  32  RAM full-word write data

Behaviour:
- Clock and reset: clock is clk. Reset rst is asynchronous and active-high.
- Reset: state=IDLE and captured request registers cleared. All outputs are 0 while rst is high, including req_ready. After release, req_ready=1.
- Byte order: little-endian. Byte k of a word is bits [8k+7:8k]. Word address = addr[ADDR_W+1:2]. Lane = addr[1:0].
- Accept: a request is accepted only in IDLE with req_valid=1 (req_ready=1 only in IDLE). The cycle of acceptance is T. addr, we, funct3 and wdata are captured at T.
- Error checks at accept, any one sets error:
  - funct3 illegal: loads allow 0,1,2,4,5; stores allow 0,1,2.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - addr >= MEM_DEPTH*4.
- States:
  - IDLE -> ERR on error.
  - IDLE -> RD on load, SB or SH.
  - IDLE -> WR on SW.
  - RD: ram_ren=1, ram_raddr=word address. Load -> LRESP. SB/SH -> MWR.
  - MWR: ram_wen=1, ram_waddr=word address. ram_wdata = ram_rdata with the addressed byte/halfword lanes replaced by req_wdata[7:0]/[15:0]; other lanes unchanged. Then -> SRESP.
  - WR: ram_wen=1, ram_wdata=req_wdata. Then -> SRESP.
  - LRESP: resp_valid=1. resp_rdata = selected lane(s) of ram_rdata: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word. Then -> IDLE.
  - SRESP: resp_valid=1, resp_rdata=0. Then -> IDLE.
  - ERR: resp_valid=1, resp_err=1, no RAM access. Then -> IDLE.
- Latency from accept T: error -> resp at T+1; load and SW -> resp at T+2; SB/SH -> resp at T+3. Next accept is possible the cycle after resp.
- RAM-side outputs: ram_ren, ram_wen and ram_wdata are 0 outside RD/MWR/WR. ram_ben is 2'b00 always.
- Response channel: no backpressure; the consumer must take resp_valid when it pulses. resp_err=1 only in ERR.
- Reset mid-operation: the FSM aborts to IDLE and no response is produced.
  - Reset during RD of an SB/SH: memory is unchanged.
  - A write is committed only if MWR/WR completed a clock edge before reset asserted.
- ram_ren and ram_wen are never asserted in the same cycle.

Decomposition:
- Package mem_pkg:
  - funct3 localparams (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5).
  - State enum lsu_state_t {IDLE, RD, MWR, WR, LRESP, SRESP, ERR}.
  - MEM_DEPTH default.
- Sub-module lsu_lane_align (combinational): load extract/extend and store merge from (funct3, lane, word, wdata). It is reused by the verification model.

Test Plan:
- Reset, then LW addr=0x10 with mem[4]=0x8899AABB -> ram_ren at T+1 with raddr=4; resp_valid at T+2 with rdata=0x8899AABB, err=0.
- LB and LBU at addr=0x13, mem[4]=0x80112233 -> LB returns 0xFFFFFF80, LBU returns 0x00000080; LH at 0x12 returns 0xFFFF8011.
- SB addr=0x11, wdata=0xDEADBEEF, mem[4]=0x11223344 -> RD at T+1; MWR at T+2 with ram_wdata=0x1122EF44, ram_ben=0; resp at T+3; a following LW reads 0x1122EF44.
- SW addr=0x2000 (=MEM_DEPTH*4) and LH addr=0x15 -> resp_err=1 at T+1; ram_wen and ram_ren stay 0 throughout.
- SH addr=0x22 with rst asserted while in RD -> outputs 0 immediately; no resp; mem[8] unchanged; req_ready=1 after release.
- Back-to-back SW then LW to the same address with req_valid held high -> second accept the cycle after the SW resp; the LW returns the stored value.
